// File: rtl/norm_shift_24bit.sv
// rtl/norm_shift_24bit.sv - two-stage mantissa normalization with exponent adjust and denormal clamp
module norm_shift_24bit #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOPD = 5,
  parameter int SIZE_EXP  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_mantissa,
  input  logic [SIZE_EXP-1:0]  i_exponent,
  input  logic                 i_sign,
  input  logic [SIZE_LOPD-1:0] i_one_position,
  input  logic                 i_zero_flag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_mantissa,
  output logic [SIZE_EXP-1:0]  o_exponent,
  output logic                 o_sign,
  output logic                 o_zero,
  output logic                 o_denorm
);

  // Largest shift that still keeps at least the LSB inside the mantissa.
  localparam logic [SIZE_EXP-1:0] MAX_SHIFT = SIZE_EXP'(SIZE_DATA - 1);

  logic en1;
  logic en2;
  logic v1;
  logic v2;

  // Stage 1 storage
  logic [SIZE_DATA-1:0] mant1;
  logic [SIZE_EXP-1:0]  exp1;
  logic [SIZE_LOPD-1:0] shamt1;
  logic                 sign1;
  logic                 zero1;
  logic                 denorm1;

  // Stage 1 next-state decisions
  logic [SIZE_EXP-1:0]  pos_ext;
  logic                 is_norm;
  logic [SIZE_EXP-1:0]  sh_raw;
  logic [SIZE_LOPD-1:0] shamt_next;
  logic [SIZE_EXP-1:0]  exp_next;
  logic                 denorm_next;

  // A stage may load when it is empty or its contents move on this edge.
  assign en2     = !v2 || i_ready;
  assign en1     = !v1 || en2;
  assign o_ready = en1;
  assign o_valid = v2;

  // Decide shift amount and result exponent from the trusted leading-one position.
  always_comb begin
    pos_ext     = {{(SIZE_EXP-SIZE_LOPD){1'b0}}, i_one_position};
    is_norm     = i_exponent > pos_ext;
    sh_raw      = '0;
    exp_next    = '0;
    denorm_next = 1'b0;
    if (is_norm) begin
      sh_raw   = pos_ext;
      exp_next = i_exponent - pos_ext;
    end else begin
      // Shift only as far as the exponent can pay for, leaving exponent 0.
      sh_raw      = (i_exponent == '0) ? '0 : i_exponent - SIZE_EXP'(1);
      denorm_next = !i_zero_flag;
    end
    if (i_zero_flag) begin
      sh_raw   = '0;
      exp_next = '0;
    end
    shamt_next = (sh_raw > MAX_SHIFT) ? MAX_SHIFT[SIZE_LOPD-1:0] : sh_raw[SIZE_LOPD-1:0];
  end

  // Stage 1: capture the beat together with its precomputed shift decision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1      <= 1'b0;
      mant1   <= '0;
      exp1    <= '0;
      shamt1  <= '0;
      sign1   <= 1'b0;
      zero1   <= 1'b0;
      denorm1 <= 1'b0;
    end else if (en1) begin
      v1 <= i_valid;
      if (i_valid) begin
        mant1   <= i_mantissa;
        exp1    <= exp_next;
        shamt1  <= shamt_next;
        sign1   <= i_sign;
        zero1   <= i_zero_flag;
        denorm1 <= denorm_next;
      end
    end
  end

  // Stage 2: apply the shift and present registered results; held while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2         <= 1'b0;
      o_mantissa <= '0;
      o_exponent <= '0;
      o_sign     <= 1'b0;
      o_zero     <= 1'b0;
      o_denorm   <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        o_mantissa <= zero1 ? '0 : (mant1 << shamt1);
        o_exponent <= exp1;
        o_sign     <= sign1;
        o_zero     <= zero1;
        o_denorm   <= denorm1;
      end
    end
  end

endmodule

// File: tb/tb_norm_shift_24bit.sv
// tb/tb_norm_shift_24bit.sv - self-checking bench for norm_shift_24bit
module tb_norm_shift_24bit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_mantissa;
  logic [7:0]  i_exponent;
  logic        i_sign;
  logic [4:0]  i_one_position;
  logic        i_zero_flag;
  logic        o_valid;
  logic        i_ready;
  logic [23:0] o_mantissa;
  logic [7:0]  o_exponent;
  logic        o_sign;
  logic        o_zero;
  logic        o_denorm;

  logic [34:0] dut_out;
  logic [34:0] exp_q[$];
  int checks;
  int errors;

  assign dut_out = {o_mantissa, o_exponent, o_sign, o_zero, o_denorm};

  norm_shift_24bit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_mantissa(i_mantissa), .i_exponent(i_exponent), .i_sign(i_sign),
    .i_one_position(i_one_position), .i_zero_flag(i_zero_flag),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_mantissa(o_mantissa), .o_exponent(o_exponent), .o_sign(o_sign),
    .o_zero(o_zero), .o_denorm(o_denorm)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: result packed as {mantissa, exponent, sign, zero, denorm}.
  function automatic logic [34:0] model(input logic [23:0] m, input int e, input logic s,
                                        input int p, input logic z);
    int sh;
    int eo;
    logic d;
    logic [23:0] mo;
    if (z) return {24'h0, 8'h0, s, 1'b1, 1'b0};
    if (e > p) begin
      sh = p; eo = e - p; d = 1'b0;
    end else begin
      sh = (e == 0) ? 0 : e - 1; eo = 0; d = 1'b1;
    end
    mo = m << sh;
    return {mo, 8'(eo), s, 1'b0, d};
  endfunction

  task automatic gen_random_beat();
    int p;
    logic [23:0] top;
    p = $urandom_range(0, 23);
    top = 24'h800000 >> p;
    i_zero_flag    = ($urandom_range(0, 9) == 0);
    i_one_position = 5'(p);
    i_mantissa     = i_zero_flag ? 24'h0 : (top | (24'($urandom) & (top - 24'h1)));
    i_exponent     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
    i_sign         = 1'($urandom);
  endtask

  task automatic test_reset();
    checks++;
    if (o_valid !== 1'b0 || dut_out !== 35'h0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state valid=%b out=%h ready=%b exp valid=0 out=0 ready=1", o_valid, dut_out, o_ready);
    end
  endtask

  task automatic test_directed();
    logic [23:0] vm[7] = '{24'h000F00, 24'h800000, 24'h000100, 24'h000000, 24'h000001, 24'h000100, 24'h000100};
    logic [7:0]  ve[7] = '{8'd100, 8'd127, 8'd5, 8'd90, 8'd0, 8'd15, 8'd16};
    logic [4:0]  vp[7] = '{5'd12, 5'd0, 5'd15, 5'd0, 5'd23, 5'd15, 5'd15};
    logic        vs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vz[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [34:0] vx[7] = '{{24'hF00000, 8'd88, 3'b100}, {24'h800000, 8'd127, 3'b000},
                           {24'h001000, 8'd0, 3'b001}, {24'h000000, 8'd0, 3'b110},
                           {24'h000001, 8'd0, 3'b001}, {24'h400000, 8'd0, 3'b101},
                           {24'h800000, 8'd1, 3'b000}};
    for (int k = 0; k < 7; k++) begin
      @(negedge i_clk);
      i_ready = 1'b1; i_valid = 1'b1;
      i_mantissa = vm[k]; i_exponent = ve[k]; i_one_position = vp[k];
      i_sign = vs[k]; i_zero_flag = vz[k];
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
        errors++; $display("FAIL directed_ready[%0d] got %b exp 1", k, o_ready);
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("FAIL directed_early_valid[%0d] got %b exp 0", k, o_valid);
      end
      @(negedge i_clk);
      #1;
      checks++;
      if (o_valid !== 1'b1 || dut_out !== vx[k]) begin
        errors++; $display("FAIL directed_result[%0d] valid=%b got %h exp %h", k, o_valid, dut_out, vx[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] bm[4] = '{24'h000F00, 24'h000100, 24'h400000, 24'h000003};
    logic [7:0]  be[4] = '{8'd100, 8'd5, 8'd1, 8'd200};
    logic [4:0]  bp[4] = '{5'd12, 5'd15, 5'd1, 5'd22};
    int sent = 0;
    int c = 0;
    logic stall_prev = 1'b0;
    logic exp_ready;
    logic [34:0] held = '0;
    exp_q.delete();
    while ((sent < 4 || exp_q.size() > 0) && c < 100) begin
      @(negedge i_clk);
      i_ready = !(c >= 2 && c <= 5);
      i_valid = (sent < 4);
      if (sent < 4) begin
        i_mantissa = bm[sent]; i_exponent = be[sent]; i_one_position = bp[sent];
        i_sign = sent[0]; i_zero_flag = 1'b0;
      end
      #1;
      exp_ready = !(exp_q.size() == 2 && !i_ready);
      checks++;
      if (o_ready !== exp_ready) begin
        errors++; $display("FAIL bp_ready cyc %0d got %b exp %b", c, o_ready, exp_ready);
      end
      if (stall_prev) begin
        checks++;
        if (dut_out !== held || o_valid !== 1'b1) begin
          errors++; $display("FAIL bp_stable cyc %0d got %h exp %h", c, dut_out, held);
        end
      end
      if (o_valid && i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra_beat got %h exp none", dut_out);
        end else if (dut_out !== exp_q[0]) begin
          errors++; $display("FAIL bp_beat got %h exp %h", dut_out, exp_q[0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_mantissa, int'(i_exponent), i_sign, int'(i_one_position), i_zero_flag));
        sent++;
      end
      stall_prev = o_valid && !i_ready;
      held = dut_out;
      c++;
    end
    i_valid = 1'b0;
    checks++;
    if (sent != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_complete sent %0d pending %0d exp sent 4 pending 0", sent, exp_q.size());
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int c = 0;
    logic have_beat = 1'b0;
    logic stall_prev = 1'b0;
    logic exp_ready;
    logic [34:0] held = '0;
    exp_q.delete();
    while ((sent < 100 || exp_q.size() > 0) && c < 3000) begin
      @(negedge i_clk);
      i_ready = ($urandom_range(0, 3) != 0);
      if (!have_beat && sent < 100 && $urandom_range(0, 3) != 0) begin
        gen_random_beat();
        have_beat = 1'b1;
      end
      i_valid = have_beat;
      #1;
      exp_ready = !(exp_q.size() == 2 && !i_ready);
      checks++;
      if (o_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, o_ready, exp_ready);
      end
      if (stall_prev) begin
        checks++;
        if (dut_out !== held || o_valid !== 1'b1) begin
          errors++; $display("FAIL rnd_stable cyc %0d got %h exp %h", c, dut_out, held);
        end
      end
      if (o_valid && i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_beat got %h exp none", dut_out);
        end else if (dut_out !== exp_q[0]) begin
          errors++; $display("FAIL rnd_beat got %h exp %h", dut_out, exp_q[0]);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_mantissa, int'(i_exponent), i_sign, int'(i_one_position), i_zero_flag));
        sent++;
        have_beat = 1'b0;
      end
      stall_prev = o_valid && !i_ready;
      held = dut_out;
      c++;
    end
    i_valid = 1'b0;
    checks++;
    if (sent != 100 || exp_q.size() != 0) begin
      errors++; $display("FAIL rnd_complete sent %0d pending %0d exp sent 100 pending 0", sent, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge i_clk);
    i_ready = 1'b0; i_valid = 1'b1;
    i_mantissa = 24'h000F00; i_exponent = 8'd100; i_one_position = 5'd12;
    i_sign = 1'b1; i_zero_flag = 1'b0;
    @(negedge i_clk);
    i_mantissa = 24'h800000; i_exponent = 8'd127; i_one_position = 5'd0;
    @(negedge i_clk);
    i_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || dut_out !== 35'h0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset valid=%b out=%h ready=%b exp valid=0 out=0 ready=1", o_valid, dut_out, o_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      #1;
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("FAIL stale_beat cyc %0d got valid %b exp 0", k, o_valid);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_mantissa = '0;
    i_exponent = '0;
    i_sign = 1'b0;
    i_one_position = '0;
    i_zero_flag = 1'b0;
    #12;
    test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
